wb_trace_monitor: RTL and testbench

//  Multi-port writeback trace collector for core-level simulation and debug. Samples
//  NUM_PORTS execution-unit writeback channels (ALU0/ALU1/LSU/...) each cycle.

---
 rtl/wb_trace_monitor.sv | 143 ++++++++++++++
 tb/tb_wb_trace_monitor.sv | 231 +++++++++++++++++++++++
 2 files changed

// File: rtl/wb_trace_monitor.sv
// rtl/wb_trace_monitor.sv - multi-port writeback trace collector with timestamped FIFO and hang detect
module wb_trace_monitor #(
   parameter int NUM_PORTS = 2,
   parameter int PC_W      = 32,
   parameter int DATA_W    = 32,
   parameter int RD_W      = 6,
   parameter int DEPTH     = 16,
   parameter int TS_W      = 32,
   parameter int TIMEOUT   = 1024
) (
   input  logic                          clk,
   input  logic                          rst,
   input  logic                          enable,
   input  logic                          clear_stats,
   input  logic [NUM_PORTS-1:0]          wb_valid,
   input  logic [NUM_PORTS*PC_W-1:0]     wb_pc,
   input  logic [NUM_PORTS*RD_W-1:0]     wb_rd,
   input  logic [NUM_PORTS*DATA_W-1:0]   wb_data,
   output logic                          trace_valid,
   input  logic                          trace_ready,
   output logic [PC_W-1:0]               trace_pc,
   output logic [RD_W-1:0]               trace_rd,
   output logic [DATA_W-1:0]             trace_data,
   output logic [$clog2(NUM_PORTS):0]    trace_port,
   output logic [TS_W-1:0]               trace_ts,
   output logic [$clog2(DEPTH):0]        fifo_level,
   output logic [TS_W-1:0]               event_count,
   output logic [TS_W-1:0]               drop_count,
   output logic                          hang
);

   localparam int AW = $clog2(DEPTH);
   localparam int LW = AW + 1;
   localparam int PW = $clog2(NUM_PORTS) + 1;
   localparam int IW = $clog2(TIMEOUT + 1);

   // Record storage; pointers carry one extra wrap bit so full and empty are exact
   logic [PC_W-1:0]   mem_pc   [DEPTH];
   logic [RD_W-1:0]   mem_rd   [DEPTH];
   logic [DATA_W-1:0] mem_data [DEPTH];
   logic [PW-1:0]     mem_port [DEPTH];
   logic [TS_W-1:0]   mem_ts   [DEPTH];

   logic [LW-1:0]     wr_ptr;
   logic [LW-1:0]     rd_ptr;
   logic [LW-1:0]     occ;
   logic [LW-1:0]     free_slots;
   logic [LW-1:0]     push_cnt;
   logic [LW-1:0]     drop_cnt;
   logic [NUM_PORTS-1:0] wr_en;
   logic [AW-1:0]     wr_addr [NUM_PORTS];
   logic [TS_W-1:0]   cycle_cnt;
   logic [IW-1:0]     idle_cnt;
   logic              any_valid;
   logic              pop;

   function automatic logic [TS_W-1:0] sat_add(input logic [TS_W-1:0] a, input logic [LW-1:0] b);
      logic [TS_W:0] s;
      s = {1'b0, a} + (TS_W+1)'(b);
      return s[TS_W] ? '1 : s[TS_W-1:0];
   endfunction

   assign occ        = wr_ptr - rd_ptr;
   assign free_slots = LW'(DEPTH) - occ;
   assign any_valid  = |wb_valid;
   assign pop        = (occ != '0) && trace_ready;

   // Slot allocation: valid ports take consecutive slots in ascending index until space runs out
   always_comb begin
      push_cnt = '0;
      drop_cnt = '0;
      wr_en    = '0;
      for (int i = 0; i < NUM_PORTS; i++) begin
         wr_addr[i] = '0;
         if (enable && wb_valid[i]) begin
            if (push_cnt < free_slots) begin
               wr_en[i]   = 1'b1;
               wr_addr[i] = wr_ptr[AW-1:0] + push_cnt[AW-1:0];
               push_cnt   = push_cnt + 1'b1;
            end else begin
               drop_cnt   = drop_cnt + 1'b1;
            end
         end
      end
   end

   // Record payload writes; storage needs no reset since pointers define validity
   always_ff @(posedge clk) begin
      for (int i = 0; i < NUM_PORTS; i++) begin
         if (wr_en[i]) begin
            mem_pc[wr_addr[i]]   <= wb_pc[i*PC_W +: PC_W];
            mem_rd[wr_addr[i]]   <= wb_rd[i*RD_W +: RD_W];
            mem_data[wr_addr[i]] <= wb_data[i*DATA_W +: DATA_W];
            mem_port[wr_addr[i]] <= PW'(i);
            mem_ts[wr_addr[i]]   <= cycle_cnt;
         end
      end
   end

   // Pointers, free-running cycle stamp, statistics and sticky hang flag
   always_ff @(posedge clk) begin
      if (rst) begin
         wr_ptr      <= '0;
         rd_ptr      <= '0;
         cycle_cnt   <= '0;
         event_count <= '0;
         drop_count  <= '0;
         idle_cnt    <= '0;
         hang        <= 1'b0;
      end else begin
         cycle_cnt <= cycle_cnt + 1'b1;
         wr_ptr    <= wr_ptr + push_cnt;
         rd_ptr    <= rd_ptr + LW'(pop);
         if (clear_stats) begin
            event_count <= '0;
            drop_count  <= '0;
            idle_cnt    <= '0;
            hang        <= 1'b0;
         end else if (enable) begin
            event_count <= sat_add(event_count, push_cnt);
            drop_count  <= sat_add(drop_count, drop_cnt);
            if (any_valid) begin
               idle_cnt <= '0;
            end else if (idle_cnt != IW'(TIMEOUT)) begin
               idle_cnt <= idle_cnt + 1'b1;
            end
            // Set on the edge where the idle count reaches TIMEOUT
            if (!any_valid && idle_cnt >= IW'(TIMEOUT - 1)) begin
               hang <= 1'b1;
            end
         end
      end
   end

   assign trace_valid = (occ != '0);
   assign trace_pc    = mem_pc[rd_ptr[AW-1:0]];
   assign trace_rd    = mem_rd[rd_ptr[AW-1:0]];
   assign trace_data  = mem_data[rd_ptr[AW-1:0]];
   assign trace_port  = mem_port[rd_ptr[AW-1:0]];
   assign trace_ts    = mem_ts[rd_ptr[AW-1:0]];
   assign fifo_level  = occ;

endmodule

// File: tb/tb_wb_trace_monitor.sv
// tb/tb_wb_trace_monitor.sv - scoreboard bench for wb_trace_monitor with randomized stimulus
module tb_wb_trace_monitor;
   localparam int NP = 2;
   localparam int PC_W = 32;
   localparam int DATA_W = 32;
   localparam int RD_W = 6;
   localparam int DEPTH = 16;
   localparam int TS_W = 8;
   localparam int TIMEOUT = 8;
   localparam int PW = $clog2(NP) + 1;
   localparam int LW = $clog2(DEPTH) + 1;
   localparam longint SAT = (64'd1 << TS_W) - 1;

   logic clk = 1'b0;
   logic rst, enable, clear_stats, trace_ready;
   logic [NP-1:0] wb_valid;
   logic [NP*PC_W-1:0] wb_pc;
   logic [NP*RD_W-1:0] wb_rd;
   logic [NP*DATA_W-1:0] wb_data;
   logic trace_valid, hang;
   logic [PC_W-1:0] trace_pc;
   logic [RD_W-1:0] trace_rd;
   logic [DATA_W-1:0] trace_data;
   logic [PW-1:0] trace_port;
   logic [TS_W-1:0] trace_ts, event_count, drop_count;
   logic [LW-1:0] fifo_level;

   wb_trace_monitor #(.NUM_PORTS(NP), .PC_W(PC_W), .DATA_W(DATA_W), .RD_W(RD_W),
                      .DEPTH(DEPTH), .TS_W(TS_W), .TIMEOUT(TIMEOUT)) dut (
      .clk(clk), .rst(rst), .enable(enable), .clear_stats(clear_stats),
      .wb_valid(wb_valid), .wb_pc(wb_pc), .wb_rd(wb_rd), .wb_data(wb_data),
      .trace_valid(trace_valid), .trace_ready(trace_ready), .trace_pc(trace_pc),
      .trace_rd(trace_rd), .trace_data(trace_data), .trace_port(trace_port),
      .trace_ts(trace_ts), .fifo_level(fifo_level), .event_count(event_count),
      .drop_count(drop_count), .hang(hang));

   always #5 clk = ~clk;

   typedef struct {
      logic [PC_W-1:0]   pc;
      logic [RD_W-1:0]   rd;
      logic [DATA_W-1:0] data;
      int                port;
      int                ts;
   } rec_t;

   rec_t   exp_q[$];
   int     total = 0, bad = 0;
   int     m_occ = 0, m_ts = 0, m_idle = 0;
   longint m_ev = 0, m_dr = 0;
   bit     m_hang = 0;
   bit     chk_on = 0;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s actual=%0h expected=%0h t=%0t", name, act, exp, $time);
      end
   endtask

   // Reference model: advances one clock using the inputs applied during the cycle just ended
   task automatic model_edge();
      int free, pushed, drops;
      bit any;
      rec_t r;
      if (rst) begin
         exp_q.delete();
         m_occ = 0; m_ts = 0; m_ev = 0; m_dr = 0; m_idle = 0; m_hang = 0;
         return;
      end
      free = DEPTH - m_occ;
      pushed = 0; drops = 0; any = 0;
      for (int i = 0; i < NP; i++) begin
         if (wb_valid[i]) any = 1;
         if (enable && wb_valid[i]) begin
            if (pushed < free) begin
               r.pc = wb_pc[i*PC_W +: PC_W];
               r.rd = wb_rd[i*RD_W +: RD_W];
               r.data = wb_data[i*DATA_W +: DATA_W];
               r.port = i;
               r.ts = m_ts;
               exp_q.push_back(r);
               pushed++;
            end else begin
               drops++;
            end
         end
      end
      if (m_occ > 0 && trace_ready) m_occ--;
      m_occ += pushed;
      if (clear_stats) begin
         m_ev = 0; m_dr = 0; m_idle = 0; m_hang = 0;
      end else if (enable) begin
         m_ev = (m_ev + pushed > SAT) ? SAT : m_ev + pushed;
         m_dr = (m_dr + drops > SAT) ? SAT : m_dr + drops;
         if (any) m_idle = 0; else m_idle++;
         if (m_idle >= TIMEOUT) m_hang = 1;
      end
      m_ts = (m_ts + 1) % (1 << TS_W);
   endtask

   task automatic step();
      @(posedge clk);
      model_edge();
      #1;
   endtask

   task automatic rand_ports();
      for (int i = 0; i < NP; i++) begin
         wb_pc[i*PC_W +: PC_W] = $urandom;
         wb_rd[i*RD_W +: RD_W] = RD_W'($urandom);
         wb_data[i*DATA_W +: DATA_W] = $urandom;
      end
   endtask

   // Monitor: compares state and pops the scoreboard whenever a record is handed off
   always @(negedge clk) begin
      rec_t r;
      if (chk_on) begin
         check("trace_valid", trace_valid, (m_occ != 0));
         check("fifo_level", fifo_level, m_occ);
         check("event_count", event_count, m_ev);
         check("drop_count", drop_count, m_dr);
         check("hang", hang, m_hang);
         if (trace_valid && trace_ready) begin
            if (exp_q.size() == 0) begin
               check("unexpected_record", 1, 0);
            end else begin
               r = exp_q.pop_front();
               check("trace_pc", trace_pc, r.pc);
               check("trace_rd", trace_rd, r.rd);
               check("trace_data", trace_data, r.data);
               check("trace_port", trace_port, r.port);
               check("trace_ts", trace_ts, r.ts);
            end
         end
      end
   end

   initial begin
      rst = 1; enable = 1; clear_stats = 0; trace_ready = 0;
      wb_valid = '0; wb_pc = '0; wb_rd = '0; wb_data = '0;
      step(); step();
      chk_on = 1;
      check("reset_valid", trace_valid, 0);
      check("reset_level", fifo_level, 0);
      rst = 0;

      // two ports in one cycle pop in port order with a common stamp
      wb_pc[0 +: PC_W] = 32'h100; wb_data[0 +: DATA_W] = 32'h1; wb_rd[0 +: RD_W] = 6'd1;
      wb_pc[PC_W +: PC_W] = 32'h104; wb_data[DATA_W +: DATA_W] = 32'h2; wb_rd[RD_W +: RD_W] = 6'd2;
      wb_valid = 2'b11; trace_ready = 1;
      step();
      wb_valid = '0;
      step(); step(); step();
      check("t1_events", event_count, 2);

      // fill with ready low: 18 offered, 16 kept
      rst = 1; step(); rst = 0;
      trace_ready = 0; wb_valid = 2'b11;
      for (int c = 0; c < 9; c++) begin rand_ports(); step(); end
      check("t2_level", fifo_level, 16);
      check("t2_drops", drop_count, 2);

      // full FIFO with pop and two pushes: the pop adds no space
      rand_ports(); trace_ready = 1;
      step();
      check("t3_level", fifo_level, 15);
      check("t3_drops", drop_count, 4);

      // idle timeout
      wb_valid = '0;
      for (int c = 0; c < 7; c++) step();
      check("t4_no_hang", hang, 0);
      step();
      check("t4_hang", hang, 1);
      wb_valid = 2'b01; rand_ports(); step();
      check("t4_hang_sticky", hang, 1);
      wb_valid = '0; clear_stats = 1; step(); clear_stats = 0;
      check("t4_hang_clear", hang, 0);
      check("t4_events_clear", event_count, 0);
      for (int c = 0; c < 20; c++) step();

      // capture disabled: queued records drain, counters frozen
      rst = 1; step(); rst = 0;
      trace_ready = 0; wb_valid = 2'b01;
      for (int c = 0; c < 3; c++) begin rand_ports(); step(); end
      enable = 0; wb_valid = 2'b11; trace_ready = 1;
      for (int c = 0; c < 5; c++) begin rand_ports(); step(); end
      check("t5_level", fifo_level, 0);
      check("t5_events", event_count, 3);
      enable = 1;

      // reset mid-drain
      wb_valid = 2'b01; trace_ready = 0;
      for (int c = 0; c < 5; c++) begin rand_ports(); step(); end
      wb_valid = '0; trace_ready = 1; step();
      rst = 1; step(); rst = 0;
      check("t6_valid", trace_valid, 0);
      check("t6_level", fifo_level, 0);
      check("t6_events", event_count, 0);
      wb_valid = 2'b10; rand_ports(); step(); wb_valid = '0; step();

      // drop counter saturation
      rst = 1; step(); rst = 0;
      trace_ready = 0; wb_valid = 2'b11;
      for (int c = 0; c < 140; c++) begin rand_ports(); step(); end
      check("sat_drops", drop_count, SAT);
      wb_valid = '0; trace_ready = 1;
      for (int c = 0; c < 20; c++) step();

      // randomized traffic
      for (int c = 0; c < 2000; c++) begin
         enable = ($urandom_range(0, 9) != 0);
         wb_valid = NP'($urandom);
         trace_ready = ($urandom_range(0, 9) < 7);
         clear_stats = ($urandom_range(0, 63) == 0);
         rst = ($urandom_range(0, 499) == 0);
         rand_ports();
         step();
      end

      rst = 0; enable = 1; clear_stats = 0; wb_valid = '0; trace_ready = 1;
      for (int c = 0; c < 20; c++) step();
      check("final_drained", exp_q.size(), 0);
      chk_on = 0;
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
